// File: rtl/vga_pkg.sv
// Shared constants for the VGA text path: switch conditioning defaults and the
// 640x480@60 frame timing also used by the sync generator.
package vga_pkg;

  localparam int unsigned N_SW            = 8;
  localparam int unsigned DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned CNT_W           = 20;
  localparam logic        VS_ACTIVE       = 1'b0;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    DB_HOLD,
    DB_COUNT,
    DB_COMMIT
  } db_action_e;

  // Retrace begins on the transition from the idle level into the active level.
  function automatic logic is_frame_start(input logic vs_prev, input logic vs_now,
                                          input logic active);
    return (vs_prev == ~active) && (vs_now == active);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, saturating persistence counter and the
// debounced stable flop.
module sw_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = vga_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = vga_pkg::CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o
);
  import vga_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  db_action_e       action;

  // Any return to the stable level drops back to HOLD, restarting the count.
  always_comb begin
    if (s2_q == stable_q) begin
      action = DB_HOLD;
    end else if (cnt_q == CNT_LAST) begin
      action = DB_COMMIT;
    end else begin
      action = DB_COUNT;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    case (action)
      DB_HOLD:   cnt_d = '0;
      DB_COUNT:  cnt_d = cnt_q + CNT_W'(1);
      DB_COMMIT: begin
        stable_d = s2_q;
        cnt_d    = '0;
      end
      default:   cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/switch_frame_latch.sv
// Debounces the board slide switches and republishes them only at the start of
// vertical retrace so the character content never changes mid-frame.
module switch_frame_latch #(
  parameter int unsigned N_SW            = vga_pkg::N_SW,
  parameter int unsigned DEBOUNCE_CYCLES = vga_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = vga_pkg::CNT_W,
  parameter logic        VS_ACTIVE       = vga_pkg::VS_ACTIVE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] switch_raw,
  input  logic            vsync,
  output logic [N_SW-1:0] switch,
  output logic            sw_changed
);
  import vga_pkg::*;

  logic [N_SW-1:0] stable;
  logic            vs_prev_q;
  logic            frame_tick;
  logic [N_SW-1:0] switch_q;
  logic [N_SW-1:0] switch_d;
  logic            changed_q;
  logic            changed_d;

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_i   (clk),
      .rst_i   (reset),
      .raw_i   (switch_raw[i]),
      .stable_o(stable[i])
    );
  end

  assign frame_tick = is_frame_start(vs_prev_q, vsync, VS_ACTIVE);

  // Publish reads the registered stable vector, so a commit landing on the
  // tick cycle is picked up one frame later.
  always_comb begin
    switch_d  = switch_q;
    changed_d = 1'b0;
    if (frame_tick) begin
      switch_d  = stable;
      changed_d = (stable != switch_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev_q <= ~VS_ACTIVE;
      switch_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      vs_prev_q <= vsync;
      switch_q  <= switch_d;
      changed_q <= changed_d;
    end
  end

  assign switch     = switch_q;
  assign sw_changed = changed_q;

endmodule

// File: tb/tb_switch_frame_latch.sv
// Bench for switch_frame_latch: window-based behavioural model checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_switch_frame_latch;

  localparam int unsigned N  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic         clk        = 1'b0;
  logic         reset      = 1'b1;
  logic         vsync      = 1'b1;
  logic [N-1:0] switch_raw = 8'hFF;
  logic [N-1:0] sw;
  logic         chg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_frame_latch #(
    .N_SW           (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW),
    .VS_ACTIVE      (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .switch_raw(switch_raw),
    .vsync     (vsync),
    .switch    (sw),
    .sw_changed(chg)
  );

  // Model: the value seen after synchronisation is the raw sample two edges
  // old; a bit flips once the last D synchronised samples all disagree with it.
  logic [N-1:0] m_p1     = '0;
  logic [N-1:0] m_p2     = '0;
  logic [N-1:0] m_stable = '0;
  logic [N-1:0] m_pub    = '0;
  logic         m_chg    = 1'b0;
  logic         m_vsprev = 1'b1;
  logic [N-1:0] hist[$];
  bit           started  = 1'b0;
  bit           m_tick;
  bit           all_mis;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p1 = '0; m_p2 = '0; m_stable = '0; m_pub = '0;
      m_chg = 1'b0; m_vsprev = 1'b1;
      hist.delete();
    end else begin
      m_tick = m_vsprev && !vsync;
      m_chg  = m_tick && (m_stable != m_pub);
      if (m_tick) m_pub = m_stable;
      hist.push_back(m_p2);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        for (int i = 0; i < N; i++) begin
          all_mis = 1'b1;
          for (int j = 0; j < D; j++)
            if (hist[j][i] == m_stable[i]) all_mis = 1'b0;
          if (all_mis) m_stable[i] = ~m_stable[i];
        end
      end
      m_p2 = m_p1;
      m_p1 = switch_raw;
      m_vsprev = vsync;
    end
    if (!reset || started) started = 1'b1;
    else started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (sw !== m_pub || chg !== m_chg) begin
        errors++;
        $display("FAIL model_cmp t=%0t switch=%h sw_changed=%b expected switch=%h sw_changed=%b",
                 $time, sw, chg, m_pub, m_chg);
      end
    end
  end

  task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got switch=%h sw_changed=%b want switch=%h sw_changed=%b",
               name, $time, act[N:1], act[0], exp[N:1], exp[0]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic frame_fall();
    vsync = 1'b0;
    cyc(1);
  endtask

  initial begin
    // 1: reset with all switches high
    cyc(3);
    chk("reset_hold", {sw, chg}, {8'h00, 1'b0});
    reset = 1'b0;
    cyc(10);
    chk("no_tick_no_publish", {sw, chg}, {8'h00, 1'b0});

    // 2: clean step, publish only after the vsync fall
    switch_raw = 8'hA5;
    cyc(20);
    chk("pre_fall_hold", {sw, chg}, {8'h00, 1'b0});
    frame_fall();
    chk("step_publish", {sw, chg}, {8'hA5, 1'b1});
    cyc(1);
    chk("step_pulse_one", {sw, chg}, {8'hA5, 1'b0});
    vsync = 1'b1;
    cyc(3);

    // 3: bounce on bit0
    switch_raw = 8'hA4;
    cyc(10);
    frame_fall();
    chk("bounce_base", {sw, chg}, {8'hA4, 1'b1});
    vsync = 1'b1;
    cyc(2);
    for (int k = 0; k < 10; k++) begin
      switch_raw[0] = ~switch_raw[0];
      cyc(2);
    end
    switch_raw[0] = 1'b1;
    cyc(4);
    frame_fall();
    chk("bounce_early", {sw, chg}, {8'hA4, 1'b0});
    vsync = 1'b1;
    cyc(3);
    frame_fall();
    chk("bounce_settled", {sw, chg}, {8'hA5, 1'b1});
    vsync = 1'b1;
    cyc(2);

    // 4: frame with no change
    cyc(5);
    frame_fall();
    chk("no_change_frame", {sw, chg}, {8'hA5, 1'b0});
    vsync = 1'b1;
    cyc(2);

    // 5: debounce commit coincides with frame_tick
    switch_raw = 8'h5A;
    cyc(5);
    frame_fall();
    chk("coincident_old", {sw, chg}, {8'hA5, 1'b0});
    vsync = 1'b1;
    cyc(3);
    frame_fall();
    chk("coincident_next", {sw, chg}, {8'h5A, 1'b1});
    vsync = 1'b1;
    cyc(2);

    // 6: reset pulsed just before a commit
    switch_raw = 8'h3C;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    chk("reset_mid", {sw, chg}, {8'h00, 1'b0});
    reset = 1'b0;
    cyc(4);
    frame_fall();
    chk("reset_restart_early", {sw, chg}, {8'h00, 1'b0});
    vsync = 1'b1;
    cyc(3);
    frame_fall();
    chk("reset_restart_done", {sw, chg}, {8'h3C, 1'b1});
    vsync = 1'b1;
    cyc(2);

    // random phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) switch_raw[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(11) == 0) vsync = ~vsync;
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
